// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 data-memory sequencer.
// State encoding, requester ids and MAR mux select values.
package lc3_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic MAR_SEL_EA   = 1'b0;
  localparam logic MAR_SEL_DATA = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    MAR,
    ACC,
    IMAR,
    RESP
  } state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

endpackage

// File: rtl/lc3_rr_arb2.sv
// Two-way round-robin arbiter between instruction fetch and the data port.
// The winner of a tie is whichever port did not win the previous grant.
module lc3_rr_arb2
  import lc3_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_f_req,
  input  logic i_d_req,
  output logic o_gnt_valid,
  output logic o_gnt_data
);

  req_id_e r_last_grant;
  req_id_e w_gnt_id;

  always_comb begin
    w_gnt_id = REQ_FETCH;
    if (i_f_req && i_d_req) begin
      w_gnt_id = (r_last_grant == REQ_DATA) ? REQ_FETCH : REQ_DATA;
    end else if (i_d_req) begin
      w_gnt_id = REQ_DATA;
    end
  end

  assign o_gnt_valid = i_en & (i_f_req | i_d_req);
  assign o_gnt_data  = (w_gnt_id == REQ_DATA);

  // Starting at DATA lets fetch win the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= REQ_DATA;
    end else if (o_gnt_valid) begin
      r_last_grant <= w_gnt_id;
    end
  end

endmodule

// File: rtl/lc3_mem_sequencer.sv
// Sequencer/arbiter for the LC3 MAR, MAR mux and single-port data RAM.
// Define LC3_MEM_INDIRECT_EN to build LDI/STI pointer-reload support.
module lc3_mem_sequencer
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_ind,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mar_le,
  output logic              mar_control,
  output logic              we,
  output logic [ADDR_W-1:0] ea,
  output logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] data_in
);

  state_e            r_state;
  state_e            w_next_state;
  req_id_e           r_port;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              w_gnt_valid;
  logic              w_gnt_data;
  logic              w_need_ptr;

  lc3_rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (r_state == IDLE),
    .i_f_req     (f_req),
    .i_d_req     (d_req),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_data  (w_gnt_data)
  );

`ifdef LC3_MEM_INDIRECT_EN
  logic r_ind;
  logic r_ptr_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ind      <= 1'b0;
      r_ptr_done <= 1'b0;
    end else if (w_gnt_valid) begin
      r_ind      <= w_gnt_data & d_ind;
      r_ptr_done <= 1'b0;
    end else if (r_state == IMAR) begin
      r_ptr_done <= 1'b1;
    end
  end

  assign w_need_ptr = r_ind & ~r_ptr_done;
`else
  logic w_unused_ind;
  assign w_unused_ind = d_ind;
  assign w_need_ptr   = 1'b0;
`endif

  // Fetch is always captured as a direct read, whatever the data-port inputs say.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_port  <= REQ_FETCH;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_gnt_valid) begin
        if (w_gnt_data) begin
          r_port  <= REQ_DATA;
          r_addr  <= d_addr;
          r_we    <= d_we;
          r_wdata <= d_wdata;
        end else begin
          r_port  <= REQ_FETCH;
          r_addr  <= f_addr;
          r_we    <= 1'b0;
          r_wdata <= '0;
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    mar_le       = 1'b0;
    mar_control  = MAR_SEL_EA;
    we           = 1'b0;
    ea           = '0;
    y            = '0;
    f_ack        = 1'b0;
    d_ack        = 1'b0;
    rdata        = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) w_next_state = MAR;
      end
      MAR: begin
        mar_le       = 1'b1;
        mar_control  = MAR_SEL_EA;
        ea           = r_addr;
        w_next_state = ACC;
      end
      ACC: begin
        if (w_need_ptr) begin
          w_next_state = IMAR;
        end else begin
          if (r_we) begin
            we = 1'b1;
            y  = r_wdata;
          end
          w_next_state = RESP;
        end
      end
`ifdef LC3_MEM_INDIRECT_EN
      IMAR: begin
        mar_le       = 1'b1;
        mar_control  = MAR_SEL_DATA;
        w_next_state = ACC;
      end
`endif
      RESP: begin
        if (r_port == REQ_DATA) d_ack = 1'b1;
        else                    f_ack = 1'b1;
        rdata        = r_we ? '0 : data_in;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// Directed bench for lc3_mem_sequencer with a behavioural MAR and RAM model.
// Indirect expectations follow LC3_MEM_INDIRECT_EN when it is defined.
module tb_lc3_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, d_req, d_we, d_ind;
  logic [15:0] f_addr, d_addr, d_wdata;
  logic        f_ack, d_ack, busy, mar_le, mar_control, we;
  logic [15:0] rdata, ea, y, dataIn;

  logic [15:0] ram [0:65535];
  logic [15:0] mar = 16'h0;
  logic        pokeEn = 1'b0;
  logic [15:0] pokeAddr, pokeData;

  int nTests = 0;
  int nFail  = 0;

  lc3_mem_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_ind(d_ind), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .rdata(rdata), .busy(busy),
    .mar_le(mar_le), .mar_control(mar_control), .we(we), .ea(ea),
    .y(y), .data_in(dataIn)
  );

  always #5 clk = ~clk;

  // External memory path: MAR loads EA or the RAM output, RAM reads asynchronously.
  assign dataIn = ram[mar];
  always @(posedge clk) begin
    if (pokeEn)  ram[pokeAddr] <= pokeData;
    else if (we) ram[mar] <= y;
    if (mar_le)  mar <= mar_control ? dataIn : ea;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nTests++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic ramPoke(input logic [15:0] a, input logic [15:0] dv);
    pokeAddr = a;
    pokeData = dv;
    pokeEn   = 1'b1;
    @(negedge clk);
    pokeEn   = 1'b0;
  endtask

  // Presents one request at the current negedge (cycle 0) and records what happens until its ack.
  task automatic applyStimulus(input logic isData, input logic txWe, input logic txInd,
                               input logic [15:0] txAddr, input logic [15:0] txWdata,
                               output int ackCyc, output int weCyc, output int weCnt,
                               output int mcCyc, output int eaAtMar,
                               output logic [15:0] rd, output int wrongAck);
    ackCyc = -1; weCyc = -1; weCnt = 0; mcCyc = -1; eaAtMar = -1; rd = 16'h0; wrongAck = 0;
    if (isData) begin
      d_req = 1'b1; d_we = txWe; d_ind = txInd; d_addr = txAddr; d_wdata = txWdata;
    end else begin
      f_req = 1'b1; f_addr = txAddr; d_we = 1'b1; d_ind = 1'b1;
    end
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) begin
        f_addr = ~txAddr; d_addr = ~txAddr; d_wdata = ~txWdata;
      end
      if (we) begin weCnt++; weCyc = k; end
      if (mar_control) mcCyc = k;
      if (k == 1 && mar_le) eaAtMar = int'(ea);
      if (isData ? f_ack : d_ack) wrongAck++;
      if (isData ? d_ack : f_ack) begin
        ackCyc = k;
        rd = rdata;
        break;
      end
    end
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_ind = 1'b0;
  endtask

  int ackCyc, weCyc, weCnt, mcCyc, eaAtMar, wrongAck;
  logic [15:0] rd;
  int ackPort [4];
  int ackAt [4];
  logic [15:0] ackData [4];
  int nAck;
  logic ackSeen;

  initial begin
    rst_n = 1'b0;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_ind = 1'b0;
    f_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    pokeAddr = 16'h0; pokeData = 16'h0;
    @(negedge clk);
    checkOutput("reset_outputs",
                {13'h0, busy, mar_le, mar_control, we, f_ack, d_ack, ea[10:0]},
                32'h0);
    checkOutput("reset_data_outputs", {rdata, y}, 32'h0);
    checkOutput("reset_ea", {16'h0, ea}, 32'h0);

    ramPoke(16'h3000, 16'h1234);
    ramPoke(16'h3001, 16'h5A5A);
    ramPoke(16'h4100, 16'h4200);
    ramPoke(16'h4200, 16'h00AA);

    // Both requesters held from reset release: fetch wins first, then strict alternation.
    f_req = 1'b1; f_addr = 16'h3000;
    d_req = 1'b1; d_we = 1'b0; d_ind = 1'b0; d_addr = 16'h3001;
    rst_n = 1'b1;
    nAck = 0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) @(negedge clk);
      if ((f_ack || d_ack) && nAck < 4) begin
        ackPort[nAck] = d_ack ? 1 : 0;
        ackAt[nAck]   = k;
        ackData[nAck] = rdata;
        nAck++;
        if (nAck == 4) break;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    checkOutput("contention_ack_count", nAck, 4);
    checkOutput("contention_first_ack_cycle", ackAt[0], 3);
    checkOutput("contention_order", {ackPort[0][7:0], ackPort[1][7:0], ackPort[2][7:0], ackPort[3][7:0]},
                32'h00010001);
    checkOutput("contention_spacing", {ackAt[1][7:0] - ackAt[0][7:0], ackAt[2][7:0] - ackAt[1][7:0],
                                       ackAt[3][7:0] - ackAt[2][7:0], 8'h0}, 32'h04040400);
    checkOutput("contention_rdata", {ackData[0], ackData[1]}, 32'h12345A5A);
    @(negedge clk);
    @(negedge clk);
    checkOutput("contention_idle", {31'h0, busy}, 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h3000, 16'h0, ackCyc, weCyc, weCnt, mcCyc, eaAtMar, rd, wrongAck);
    checkOutput("fetch_ea_at_mar", eaAtMar, 32'h3000);
    checkOutput("fetch_ack_cycle", ackCyc, 3);
    checkOutput("fetch_rdata", {16'h0, rd}, 32'h1234);
    checkOutput("fetch_no_write", weCnt, 0);
    checkOutput("fetch_mar_ctl", mcCyc, -1);
    @(negedge clk);
    checkOutput("fetch_after_idle", {30'h0, busy, f_ack}, 32'h0);

    applyStimulus(1'b1, 1'b1, 1'b0, 16'h4000, 16'hBEEF, ackCyc, weCyc, weCnt, mcCyc, eaAtMar, rd, wrongAck);
    checkOutput("store_ea_at_mar", eaAtMar, 32'h4000);
    checkOutput("store_we_cycle", {weCyc[15:0], weCnt[15:0]}, {16'd2, 16'd1});
    checkOutput("store_ack_cycle", ackCyc, 3);
    checkOutput("store_rdata_zero", {16'h0, rd}, 32'h0);
    checkOutput("store_wrong_port", wrongAck, 0);
    @(negedge clk);
    checkOutput("store_ram", {16'h0, ram[16'h4000]}, 32'hBEEF);

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h4000, 16'h0, ackCyc, weCyc, weCnt, mcCyc, eaAtMar, rd, wrongAck);
    checkOutput("fetch_after_store", {ackCyc[15:0], rd}, {16'd3, 16'hBEEF});
    @(negedge clk);

`ifdef LC3_MEM_INDIRECT_EN
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h4100, 16'h0, ackCyc, weCyc, weCnt, mcCyc, eaAtMar, rd, wrongAck);
    checkOutput("ldi_mar_ctl_cycle", mcCyc, 3);
    checkOutput("ldi_ack_cycle", ackCyc, 5);
    checkOutput("ldi_rdata", {16'h0, rd}, 32'h00AA);
    checkOutput("ldi_no_write", weCnt, 0);
    @(negedge clk);
    ramPoke(16'h4100, 16'h4300);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h4100, 16'h5555, ackCyc, weCyc, weCnt, mcCyc, eaAtMar, rd, wrongAck);
    checkOutput("sti_we_cycle", {weCyc[15:0], weCnt[15:0]}, {16'd4, 16'd1});
    checkOutput("sti_ack_cycle", ackCyc, 5);
    @(negedge clk);
    checkOutput("sti_ram_target", {16'h0, ram[16'h4300]}, 32'h5555);
    checkOutput("sti_ram_pointer", {16'h0, ram[16'h4100]}, 32'h4300);
`else
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h4100, 16'h0, ackCyc, weCyc, weCnt, mcCyc, eaAtMar, rd, wrongAck);
    checkOutput("ind_ignored_load_ack", ackCyc, 3);
    checkOutput("ind_ignored_load_rdata", {16'h0, rd}, 32'h4200);
    checkOutput("ind_ignored_mar_ctl", mcCyc, -1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h4400, 16'h5555, ackCyc, weCyc, weCnt, mcCyc, eaAtMar, rd, wrongAck);
    checkOutput("ind_ignored_store", {ackCyc[7:0], weCyc[7:0], weCnt[15:0]}, {8'd3, 8'd2, 16'd1});
    @(negedge clk);
    checkOutput("ind_ignored_store_ram", {16'h0, ram[16'h4400]}, 32'h5555);
`endif

    // Reset lands in the write cycle of a store: nothing commits and no ack follows.
    ramPoke(16'h4500, 16'h0000);
    d_req = 1'b1; d_we = 1'b1; d_ind = 1'b0; d_addr = 16'h4500; d_wdata = 16'h7777;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_we_before_reset", {31'h0, we}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_async_outputs",
                {9'h0, busy, mar_le, mar_control, we, f_ack, d_ack, rdata, ea[0]}, 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    ackSeen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ackSeen = ackSeen | f_ack | d_ack;
    end
    checkOutput("abort_no_ack", {31'h0, ackSeen}, 32'h0);
    checkOutput("abort_ram_unchanged", {16'h0, ram[16'h4500]}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h4500, 16'h7777, ackCyc, weCyc, weCnt, mcCyc, eaAtMar, rd, wrongAck);
    checkOutput("reissue_ack_cycle", ackCyc, 3);
    @(negedge clk);
    checkOutput("reissue_ram", {16'h0, ram[16'h4500]}, 32'h7777);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/lc3_mem_sequencer.md
Name: lc3_mem_sequencer

Overview:
- Controller and arbiter for the LC3 data-memory path: the MAR register, the MAR source mux (EA or DATA) and the single-port data RAM.
- Shares that path between two requesters: instruction fetch, and the data port for load/store, including the indirect forms LDI/STI.
- Sequences the MAR load, the RAM access and the indirect pointer reload.
- Returns read data with a req/ack handshake.

Parameters:
- ADDR_W, 16, address width; matches the MAR and the RAM address.
- DATA_W, 16, data width; matches the RAM and MDR.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request; held until f_ack.
- f_addr  in  ADDR_W  fetch address.
- f_ack  out  1  fetch done; 1-cycle pulse; rdata valid in the same cycle.
- d_req  in  1  data-port request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_ind  in  1  indirect access (LDI/STI).
- d_addr  in  ADDR_W  data address; for indirect, the pointer address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  data-port done; 1-cycle pulse.
- rdata  out  DATA_W  read data; valid only with f_ack or d_ack (load).
- busy  out  1  high in every state except IDLE.
- mar_le  out  1  MAR load enable.
- mar_control  out  1  MAR mux select; 0 = EA, 1 = DATA.
- we  out  1  RAM write enable.
- ea  out  ADDR_W  EA input of the memory path.
- y  out  DATA_W  RAM write data.
- data_in  in  DATA_W  RAM read data (MDR); valid the cycle after the MAR is loaded.

Behaviour:
- Reset values: state IDLE; all outputs 0; last_grant = DATA, so fetch wins the first tie.
- Reset asserted mid-operation: the transaction is dropped; no ack is issued; the requester must re-present it.
- Requests are sampled only in IDLE.
- Grant rule:
  - One requester active: it wins.
  - Both active: round-robin; the winner is the port not in last_grant.
  - last_grant updates on grant.
- The granted request (address, we, ind, wdata) is captured into internal registers on the grant edge. Inputs may change after grant.
- FSM states and transitions:
  - IDLE: no req stays in IDLE; otherwise grant and go to MAR.
  - MAR: mar_le=1, mar_control=0, ea=captured address. Go to ACC.
  - ACC:
    - Indirect with pointer not yet read (no RAM write): go to IMAR.
    - Else if store: we=1, y=captured wdata; go to RESP.
    - Else (load): go to RESP.
  - IMAR: mar_le=1, mar_control=1, so the MAR loads the pointer from DATA. Set the ptr_done flag. Go to ACC.
  - RESP: ack pulse to the granted port; rdata=data_in on loads, 0 on stores. Go to IDLE.
- Latency from the grant cycle N (IDLE with req) to ack:
  - Direct load or store: ack at N+3.
  - Indirect load or store: ack at N+5.
- Exactly one idle cycle separates transactions, so back-to-back requesters alternate.
- we is never high outside ACC, and never during the pointer read of an indirect access.
- Fetch ignores d_we and d_ind; it is always a direct read.
- Address wrap: none is applied; the full ADDR_W value is passed through unchanged.
- A req dropped before its ack is a protocol violation. The controller completes the transaction anyway and still pulses ack.

Optional Feature:
- Macro: LC3_MEM_INDIRECT_EN.
- Defined: indirect support as described above.
- Undefined:
  - d_ind is ignored.
  - The IMAR state and the ptr_done flag are not built.
  - mar_control is tied to 0.
  - Every data access is direct, with N+3 latency.

Decomposition:
- Package lc3_mem_pkg:
  - State enum (IDLE, MAR, ACC, IMAR, RESP).
  - Requester id enum (REQ_FETCH, REQ_DATA).
  - Constants MAR_SEL_EA=0 and MAR_SEL_DATA=1.
  - Default widths, 16.
- Sub-module lc3_rr_arb2: 2-way round-robin grant with the last_grant register, enabled only in IDLE.

Test Plan:
- Direct load: f_req=1, f_addr=0x3000, RAM[0x3000]=0x1234 → mar_le=1 at N+1 with ea=0x3000; f_ack=1 and rdata=0x1234 at N+3.
- Direct store: d_req, d_we=1, d_addr=0x4000, d_wdata=0xBEEF → we=1 only at N+2; d_ack at N+3; a subsequent fetch of 0x4000 returns 0xBEEF.
- Indirect load (macro defined): RAM[0x4100]=0x4200, RAM[0x4200]=0x00AA; d_ind=1, d_addr=0x4100 → mar_control=1 at N+3; d_ack and rdata=0x00AA at N+5.
- Indirect store: RAM[0x4100]=0x4300, d_wdata=0x5555 → we=1 only at N+4; RAM[0x4300]=0x5555 and RAM[0x4100] unchanged.
- Contention: f_req and d_req held continuously from reset → grants alternate fetch, data, fetch, data; each ack is separated by 4 cycles.
- Reset: rst_n low at N+2 of a store → outputs 0 asynchronously; no ack; RAM unchanged; after release, the re-issued request completes normally.
